// File: rtl/hebbian_pkg.sv
// Shared types, constants and helpers for the Hebbian teacher block.
package hebbian_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    COMPUTE = 2'd2,
    APPLY   = 2'd3
  } state_t;

  // Default feedback width and the matching saturation bounds.
  localparam int     ERR_W_DEF = 16;
  localparam longint ERR_MAX   = (longint'(1) <<< (ERR_W_DEF - 1)) - 1;
  localparam longint ERR_MIN   = -(longint'(1) <<< (ERR_W_DEF - 1));

  // True when |diff| <= deadband, i.e. the neuron is close enough to target.
  function automatic logic abs_le_deadband(input longint diff, input longint deadband);
    return (diff <= deadband) && (diff >= -deadband);
  endfunction

endpackage

// File: rtl/hebbian_trainer_err_saturator.sv
// Combinational signed subtract (target - output) at OUT_W+1 bits,
// saturated to ERR_W, plus a flag for errors inside the deadband.
module err_saturator
  import hebbian_pkg::*;
#(
  parameter int OUT_W    = 32,
  parameter int ERR_W    = ERR_W_DEF,
  parameter int DEADBAND = 16
) (
  input  logic [OUT_W-1:0] a,
  input  logic [OUT_W-1:0] b,
  output logic [ERR_W-1:0] err,
  output logic             in_deadband
);

  localparam longint SAT_MAX = (longint'(1) <<< (ERR_W - 1)) - 1;
  localparam longint SAT_MIN = -(longint'(1) <<< (ERR_W - 1));

  logic signed [OUT_W:0] diff;
  longint                diff_l;

  assign diff   = $signed({a[OUT_W-1], a}) - $signed({b[OUT_W-1], b});
  assign diff_l = longint'(diff);

  // Clamp the wide difference into the feedback range and flag the deadband.
  always_comb begin
    in_deadband = abs_le_deadband(diff_l, longint'(DEADBAND));
    if (diff_l > SAT_MAX) begin
      err = ERR_W'(SAT_MAX);
    end else if (diff_l < SAT_MIN) begin
      err = ERR_W'(SAT_MIN);
    end else begin
      err = ERR_W'(diff_l);
    end
  end

endmodule

// File: rtl/hebbian_trainer.sv
// Supervisory teacher: accepts targets, waits for the neuron to settle,
// computes a saturated error and strobes enable_learning, with a
// per-epoch cap on the number of weight updates.
module hebbian_trainer
  import hebbian_pkg::*;
#(
  parameter int OUT_W         = 32,
  parameter int ERR_W         = 16,
  parameter int DEADBAND      = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_UPDATES   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             train_en,
  input  logic             target_valid,
  output logic             target_ready,
  input  logic [OUT_W-1:0] target,
  input  logic [OUT_W-1:0] neuron_output,
  output logic [ERR_W-1:0] feedback_error,
  output logic             enable_learning,
  output logic [7:0]       update_count,
  output logic             epoch_done
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   tgt_q, tgt_d;
  logic [ERR_W-1:0]   fb_q, fb_d;
  logic               learn_q, learn_d;
  logic [7:0]         count_q, count_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  logic [ERR_W-1:0]   sat_err;
  logic               in_db;

  err_saturator #(
    .OUT_W   (OUT_W),
    .ERR_W   (ERR_W),
    .DEADBAND(DEADBAND)
  ) u_sat (
    .a          (tgt_q),
    .b          (neuron_output),
    .err        (sat_err),
    .in_deadband(in_db)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      fb_q    <= '0;
      learn_q <= 1'b0;
      count_q <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      fb_q    <= fb_d;
      learn_q <= learn_d;
      count_q <= count_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and next-output logic; the learning strobe is registered on
  // the edge that leaves APPLY so it lands one cycle after the error.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    fb_d    = fb_q;
    learn_d = 1'b0;
    count_d = count_q;
    done_d  = done_q;
    ready_d = ready_q;

    if (!train_en) begin
      state_d = IDLE;
      fb_d    = '0;
      count_d = '0;
      done_d  = 1'b0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (target_valid && ready_q) begin
            tgt_d   = target;
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d = COMPUTE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        COMPUTE: begin
          if (in_db) begin
            fb_d    = '0;
            state_d = IDLE;
          end else begin
            fb_d    = sat_err;
            state_d = APPLY;
          end
        end
        APPLY: begin
          learn_d = 1'b1;
          count_d = count_q + 8'd1;
          if (count_d == 8'(MAX_UPDATES)) begin
            done_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE) && !done_d;
    end
  end

  assign target_ready    = ready_q;
  assign feedback_error  = fb_q;
  assign enable_learning = learn_q;
  assign update_count    = count_q;
  assign epoch_done      = done_q;

endmodule

// File: doc/hebbian_trainer.md
Name: hebbian_trainer

Overview:
Supervisory teacher that drives the learning side of a plastic neuron. It accepts target values over a valid/ready handshake and waits for the neuron output to settle. It then computes a saturated signed error and issues a single-cycle enable_learning pulse together with feedback_error. It limits the number of weight updates per training epoch and sits between the training-data source and the neuron's feedback_error/enable_learning inputs.

Parameters:
OUT_W, 32, width of neuron_output and target (signed)
ERR_W, 16, width of feedback_error (signed)
DEADBAND, 16, |error| <= DEADBAND is treated as converged; no update is issued
SETTLE_CYCLES, 2, cycles to wait after accepting a target before sampling neuron_output (minimum 1)
MAX_UPDATES, 255, weight updates allowed per epoch (1..255)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
train_en  in  1  training enable; low aborts training and clears the epoch
target_valid  in  1  target handshake valid
target_ready  out  1  target handshake ready
target  in  OUT_W  desired neuron output (signed)
neuron_output  in  OUT_W  registered output of the neuron (signed)
feedback_error  out  ERR_W  saturated target - neuron_output (signed)
enable_learning  out  1  one-cycle plasticity strobe
update_count  out  8  updates issued in the current epoch
epoch_done  out  1  sticky flag: update budget exhausted

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; target_ready 0; internal target register 0.
- FSM states are IDLE, SETTLE, COMPUTE, APPLY. All outputs are registered.
- IDLE: target_ready = train_en && !epoch_done. A target is accepted on an edge where target_valid && target_ready. That edge latches target, loads the settle counter with SETTLE_CYCLES-1 and enters SETTLE.
- SETTLE: target_ready 0. Decrement the counter; at 0 go to COMPUTE.
- COMPUTE: diff = target - neuron_output, evaluated at OUT_W+1 bits signed. Saturate diff to ERR_W: values above 32767 give 32767; values below -32768 give -32768.
  - If |diff| <= DEADBAND: feedback_error <= 0, return to IDLE, no pulse, update_count unchanged.
  - Otherwise: feedback_error <= saturated diff, go to APPLY.
- APPLY: enable_learning = 1 for exactly this one cycle. update_count increments. If the new count equals MAX_UPDATES, epoch_done <= 1. Return to IDLE.
- feedback_error holds its value until the next COMPUTE or until cleared.
- Latency: enable_learning is high in the cycle beginning SETTLE_CYCLES+2 edges after the accept edge. feedback_error is valid from one cycle before the pulse.
- Back-to-back throughput: one target per SETTLE_CYCLES+3 cycles, or SETTLE_CYCLES+2 for deadband samples.
- epoch_done is sticky. While it is set, target_ready stays 0 and target_valid is ignored.
- train_en low, sampled in any state, takes priority over all other transitions on the next edge:
  - state <= IDLE; enable_learning <= 0; feedback_error <= 0; update_count <= 0; epoch_done <= 0.
  - An in-flight target is discarded and no pulse is issued.
- update_count never wraps because the epoch ends at MAX_UPDATES.
- target may change while the FSM is not in IDLE; only the latched value is used.

Decomposition:
- Package hebbian_pkg holds:
  - the state enum (IDLE, SETTLE, COMPUTE, APPLY);
  - the ERR_MAX/ERR_MIN saturation constants derived from ERR_W;
  - a function abs_le_deadband.
- One sub-module, err_saturator: a combinational OUT_W+1 to ERR_W signed saturating subtractor that also outputs an in_deadband flag. It is instantiated once, and all FSM and counter logic stays in hebbian_trainer.

Test Plan:
- Nominal update (defaults): target=5000, neuron_output=1000, accept at edge E. Expect feedback_error=4000 from E+3 and enable_learning=1 only during cycle E+4; update_count becomes 1.
- Deadband: target=1000, neuron_output=1010 (diff -10). Expect no enable_learning pulse, feedback_error=0, update_count unchanged, target_ready=1 again at E+4.
- Saturation: target=100000, neuron_output=0 gives feedback_error=32767. target=-100000, neuron_output=0 gives -32768. target=-20, neuron_output=0 gives -20 with a pulse.
- Epoch budget (MAX_UPDATES=3): four back-to-back non-deadband targets. Expect three pulses; epoch_done=1 after the third APPLY; target_ready stays 0 and the fourth target is never accepted. Toggling train_en low for 1 cycle clears epoch_done and update_count.
- Abort: drop train_en during SETTLE. Expect no pulse, state IDLE on the next edge, feedback_error=0, update_count=0.
- Async reset: assert rst_n=0 mid-APPLY, between edges. Expect enable_learning, feedback_error, update_count, epoch_done and target_ready all 0 immediately; after release, normal operation resumes from IDLE.
